// File: rtl/visitor_pkg.sv
// Shared types and defaults for the visitor counter front-end.
package visitor_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StEn1,
        StEn2,
        StEn3,
        StEx1,
        StEx2,
        StEx3,
        StClr
    } state_e;

    // Sensor patterns as {so, si}.
    localparam logic [1:0] PatNone = 2'b00;
    localparam logic [1:0] PatIn   = 2'b01;
    localparam logic [1:0] PatOut  = 2'b10;
    localparam logic [1:0] PatBoth = 2'b11;

    localparam int unsigned DefWidth      = 8;
    localparam int unsigned DefMaxCount   = 99;
    localparam int unsigned DefTimeoutCyc = 1000;

    function automatic logic is_active(state_e s);
        return (s != StIdle) && (s != StClr);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/visitor_dir_counter.sv
// Doorway direction decoder with timeout and a saturating occupancy count.
module visitor_dir_counter
    import visitor_pkg::*;
#(
    parameter int unsigned WIDTH       = DefWidth,
    parameter int unsigned MAX_COUNT   = DefMaxCount,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_out,
    input  logic             s_in,
    output logic [WIDTH-1:0] count,
    output logic             entry_pulse,
    output logic             exit_pulse,
    output logic             err_pulse,
    output logic             full,
    output logic             empty
);

    localparam int unsigned TmrWidth = $clog2(TIMEOUT_CYC);
    localparam logic [TmrWidth-1:0] TmrLast = TmrWidth'(TIMEOUT_CYC - 1);
    localparam logic [WIDTH-1:0] CntMax = WIDTH'(MAX_COUNT);

    logic so;
    logic si;

    sync2 u_sync_out (
        .clk (clk),
        .rst (rst),
        .d   (s_out),
        .q   (so)
    );

    sync2 u_sync_in (
        .clk (clk),
        .rst (rst),
        .d   (s_in),
        .q   (si)
    );

    state_e              state_q;
    state_e              state_d;
    logic [TmrWidth-1:0] tmr_q;
    logic                entry_done;
    logic                exit_done;
    logic [1:0]          pat;
    logic [WIDTH-1:0]    count_d;
    logic                entry_d;
    logic                exit_d;
    logic                err_d;

    assign pat = {so, si};

    always_comb begin
        state_d    = state_q;
        entry_done = 1'b0;
        exit_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                case (pat)
                    PatOut:  state_d = StEn1;
                    PatIn:   state_d = StEx1;
                    PatBoth: state_d = StClr;
                    default: state_d = StIdle;
                endcase
            end
            StEn1: begin
                case (pat)
                    PatOut:  state_d = StEn1;
                    PatBoth: state_d = StEn2;
                    PatNone: state_d = StIdle;
                    default: state_d = StClr;
                endcase
            end
            StEn2: begin
                case (pat)
                    PatBoth: state_d = StEn2;
                    PatIn:   state_d = StEn3;
                    PatOut:  state_d = StEn1;
                    default: state_d = StIdle;
                endcase
            end
            StEn3: begin
                case (pat)
                    PatIn:   state_d = StEn3;
                    PatBoth: state_d = StEn2;
                    PatNone: begin
                        state_d    = StIdle;
                        entry_done = 1'b1;
                    end
                    default: state_d = StClr;
                endcase
            end
            StEx1: begin
                case (pat)
                    PatIn:   state_d = StEx1;
                    PatBoth: state_d = StEx2;
                    PatNone: state_d = StIdle;
                    default: state_d = StClr;
                endcase
            end
            StEx2: begin
                case (pat)
                    PatBoth: state_d = StEx2;
                    PatOut:  state_d = StEx3;
                    PatIn:   state_d = StEx1;
                    default: state_d = StIdle;
                endcase
            end
            StEx3: begin
                case (pat)
                    PatOut:  state_d = StEx3;
                    PatBoth: state_d = StEx2;
                    PatNone: begin
                        state_d   = StIdle;
                        exit_done = 1'b1;
                    end
                    default: state_d = StClr;
                endcase
            end
            StClr: begin
                if (pat == PatNone) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A stalled crossing is abandoned even if it would have completed this cycle.
        if (is_active(state_q) && (tmr_q == TmrLast)) begin
            state_d    = StClr;
            entry_done = 1'b0;
            exit_done  = 1'b0;
        end
    end

    always_comb begin
        count_d = count;
        entry_d = 1'b0;
        exit_d  = 1'b0;
        err_d   = 1'b0;
        if (entry_done) begin
            if (count < CntMax) begin
                count_d = count + 1'b1;
                entry_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (exit_done) begin
            if (count != '0) begin
                count_d = count - 1'b1;
                exit_d  = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tmr_q       <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            entry_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
            err_pulse   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                tmr_q <= '0;
            end else if (is_active(state_q)) begin
                tmr_q <= tmr_q + 1'b1;
            end else begin
                tmr_q <= '0;
            end
            count       <= count_d;
            full        <= (count_d == CntMax);
            empty       <= (count_d == '0);
            entry_pulse <= entry_d;
            exit_pulse  <= exit_d;
            err_pulse   <= err_d;
        end
    end

endmodule

// File: tb/tb_visitor_dir_counter.sv
// Bench for visitor_dir_counter: two instances (small and default capacity) on shared sensors.
module tb_visitor_dir_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_out = 1'b0;
    logic       s_in = 1'b0;

    logic [7:0] cnt_a, cnt_b;
    logic       ent_a, ext_a, err_a, full_a, empty_a;
    logic       ent_b, ext_b, err_b, full_b, empty_b;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    visitor_dir_counter #(
        .WIDTH       (8),
        .MAX_COUNT   (3),
        .TIMEOUT_CYC (16)
    ) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .s_out       (s_out),
        .s_in        (s_in),
        .count       (cnt_a),
        .entry_pulse (ent_a),
        .exit_pulse  (ext_a),
        .err_pulse   (err_a),
        .full        (full_a),
        .empty       (empty_a)
    );

    visitor_dir_counter #(
        .WIDTH       (8),
        .MAX_COUNT   (99),
        .TIMEOUT_CYC (1000)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .s_out       (s_out),
        .s_in        (s_in),
        .count       (cnt_b),
        .entry_pulse (ent_b),
        .exit_pulse  (ext_b),
        .err_pulse   (err_b),
        .full        (full_b),
        .empty       (empty_b)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Model: a crossing is a direction (+1 entry, -1 exit) and a step 1..3 along its pattern list.
    int      m_dir[2];
    int      m_k[2];
    int      m_tmr[2];
    int      m_cnt[2];
    bit      m_clr[2];
    bit      m_ent[2];
    bit      m_exi[2];
    bit      m_err[2];
    bit [1:0] m_s1, m_s2;
    bit      m_live = 1'b0;

    function automatic int max_of(int i);
        return (i == 0) ? 3 : 99;
    endfunction

    function automatic int tmo_of(int i);
        return (i == 0) ? 16 : 1000;
    endfunction

    function automatic bit [1:0] seq_pat(int dir, int k);
        if (k == 2) return 2'b11;
        if (k == 1) return (dir > 0) ? 2'b10 : 2'b01;
        return (dir > 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic model_step();
        bit [1:0] p;
        int ndir, nk;
        bit nclr, fin, changed;
        p = m_s2;
        for (int i = 0; i < 2; i++) begin
            m_ent[i] = 1'b0;
            m_exi[i] = 1'b0;
            m_err[i] = 1'b0;
            if (rst) begin
                m_dir[i] = 0;
                m_k[i]   = 0;
                m_clr[i] = 1'b0;
                m_tmr[i] = 0;
                m_cnt[i] = 0;
            end else begin
                ndir = m_dir[i];
                nk   = m_k[i];
                nclr = m_clr[i];
                fin  = 1'b0;
                if (m_clr[i]) begin
                    if (p == 2'b00) nclr = 1'b0;
                end else if (m_dir[i] == 0) begin
                    if (p == 2'b10) begin
                        ndir = 1; nk = 1;
                    end else if (p == 2'b01) begin
                        ndir = -1; nk = 1;
                    end else if (p == 2'b11) begin
                        nclr = 1'b1;
                    end
                end else begin
                    if (p == seq_pat(m_dir[i], m_k[i])) begin
                        nk = m_k[i];
                    end else if (m_k[i] < 3 && p == seq_pat(m_dir[i], m_k[i] + 1)) begin
                        nk = m_k[i] + 1;
                    end else if (m_k[i] > 1 && p == seq_pat(m_dir[i], m_k[i] - 1)) begin
                        nk = m_k[i] - 1;
                    end else if (p == 2'b00) begin
                        ndir = 0; nk = 0; fin = (m_k[i] == 3);
                    end else begin
                        ndir = 0; nk = 0; nclr = 1'b1;
                    end
                    if (m_tmr[i] == tmo_of(i) - 1) begin
                        ndir = 0; nk = 0; nclr = 1'b1; fin = 1'b0;
                    end
                end
                changed = (ndir != m_dir[i]) || (nk != m_k[i]) || (nclr != m_clr[i]);
                if (changed) m_tmr[i] = 0;
                else if (m_dir[i] != 0) m_tmr[i] = m_tmr[i] + 1;
                else m_tmr[i] = 0;
                if (fin && m_dir[i] > 0) begin
                    if (m_cnt[i] < max_of(i)) begin
                        m_cnt[i]++; m_ent[i] = 1'b1;
                    end else m_err[i] = 1'b1;
                end else if (fin) begin
                    if (m_cnt[i] > 0) begin
                        m_cnt[i]--; m_exi[i] = 1'b1;
                    end else m_err[i] = 1'b1;
                end
                m_dir[i] = ndir;
                m_k[i]   = nk;
                m_clr[i] = nclr;
            end
        end
        if (rst) begin
            m_s1 = 2'b00;
            m_s2 = 2'b00;
        end else begin
            m_s2 = m_s1;
            m_s1 = {s_out, s_in};
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        m_live = 1'b1;
    end

    task automatic compare_one(int i, logic [7:0] c, logic en, logic ex, logic er,
                               logic fu, logic em);
        string tag;
        tag = (i == 0) ? "a" : "b";
        chk({"count_", tag}, 32'(c), 32'(m_cnt[i]));
        chk({"entry_pulse_", tag}, 32'(en), 32'(m_ent[i]));
        chk({"exit_pulse_", tag}, 32'(ex), 32'(m_exi[i]));
        chk({"err_pulse_", tag}, 32'(er), 32'(m_err[i]));
        chk({"full_", tag}, 32'(fu), 32'(m_cnt[i] == max_of(i)));
        chk({"empty_", tag}, 32'(em), 32'(m_cnt[i] == 0));
    endtask

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            compare_one(0, cnt_a, ent_a, ext_a, err_a, full_a, empty_a);
            compare_one(1, cnt_b, ent_b, ext_b, err_b, full_b, empty_b);
        end
    end

    task automatic apply(logic [1:0] p, int n);
        s_out = p[1];
        s_in  = p[0];
        repeat (n) @(negedge clk);
    endtask

    task automatic do_entry();
        apply(2'b10, 5); apply(2'b11, 5); apply(2'b01, 5); apply(2'b00, 5);
    endtask

    task automatic do_exit();
        apply(2'b01, 5); apply(2'b11, 5); apply(2'b10, 5); apply(2'b00, 5);
    endtask

    initial begin
        rst   = 1'b1;
        s_out = 1'($urandom);
        s_in  = 1'($urandom);
        @(negedge clk);
        s_out = 1'($urandom);
        s_in  = 1'($urandom);
        @(negedge clk);
        chk("reset_count", 32'(cnt_a), 32'd0);
        chk("reset_empty", 32'(empty_a), 32'd1);
        chk("reset_full", 32'(full_a), 32'd0);
        chk("reset_pulses", 32'({ent_b, ext_b, err_b}), 32'd0);
        rst = 1'b0;
        apply(2'b00, 3);

        // Single entry with the pulse pinned to the third edge after the final 00.
        apply(2'b10, 5); apply(2'b11, 5); apply(2'b01, 5);
        apply(2'b00, 2);
        chk("entry_pulse_early", 32'(ent_b), 32'd0);
        @(negedge clk);
        chk("entry_pulse_edge3", 32'(ent_b), 32'd1);
        chk("entry_count", 32'(cnt_b), 32'd1);
        apply(2'b00, 2);
        do_exit();
        chk("exit_count", 32'(cnt_a), 32'd0);
        chk("exit_empty", 32'(empty_a), 32'd1);

        // Back-out, then illegal jump through CLR, then a normal entry.
        apply(2'b10, 5); apply(2'b11, 5); apply(2'b10, 5); apply(2'b00, 5);
        chk("backout_count", 32'(cnt_b), 32'd0);
        apply(2'b11, 5); apply(2'b01, 5); apply(2'b00, 5);
        chk("illegal_count", 32'(cnt_b), 32'd0);
        do_entry();
        chk("after_illegal_count", 32'(cnt_b), 32'd1);
        do_exit();

        // Saturation on the capacity-3 instance.
        do_entry(); do_entry(); do_entry();
        chk("sat_count3", 32'(cnt_a), 32'd3);
        chk("sat_full", 32'(full_a), 32'd1);
        do_entry();
        chk("sat_hold", 32'(cnt_a), 32'd3);
        chk("sat_b_count4", 32'(cnt_b), 32'd4);
        do_exit(); do_exit(); do_exit();
        chk("drain_count", 32'(cnt_a), 32'd0);
        do_exit();
        chk("underflow_hold", 32'(cnt_a), 32'd0);
        chk("underflow_b", 32'(cnt_b), 32'd0);

        // Timeout: instance a abandons, instance b backs out on release.
        apply(2'b10, 20);
        apply(2'b00, 5);
        chk("timeout_no_event", 32'(cnt_a), 32'd0);
        do_entry();
        chk("timeout_then_entry_a", 32'(cnt_a), 32'd1);
        chk("timeout_then_entry_b", 32'(cnt_b), 32'd1);

        // Reset while sitting in the last entry step.
        do_entry(); do_entry(); do_entry(); do_entry();
        chk("pre_reset_b", 32'(cnt_b), 32'd5);
        apply(2'b10, 5); apply(2'b11, 5); apply(2'b01, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        apply(2'b00, 10);
        chk("midreset_count_b", 32'(cnt_b), 32'd0);
        chk("midreset_count_a", 32'(cnt_a), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
